ac_motor_vector_dwell: RTL and testbench

AC_MOTOR_VECTOR_DWELL -- requirements
Module: ac_motor_vector_dwell

---
 rtl/ac_motor_vector_dwell.sv | 213 +++++++++++++++++++++
 tb/tb_ac_motor_vector_dwell.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_vector_dwell.sv
// Space-vector dwell-time calculator: modulation index and sector sines -> T_0/T_1/T_2/T_7 in clocks.
// Define AC_MOTOR_VECTOR_OVERMOD_EN to rescale overmodulated results with a restoring divider instead of clamping.
module ac_motor_vector_dwell #(
   parameter int BITS   = 12,
   parameter int T_BITS = 15,
   parameter int F_CLK  = 100000000,
   parameter int F_TAST = 10000
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [BITS-1:0]   U_STR,
   input  logic [BITS-1:0]   SIN_POSITIVE,
   input  logic [BITS-1:0]   SIN_NEGATIVE,
   output logic [T_BITS-1:0] T_0,
   output logic [T_BITS-1:0] T_1,
   output logic [T_BITS-1:0] T_2,
   output logic [T_BITS-1:0] T_7,
   output logic              OUT_VALID,
   output logic              OVERMOD
);
   localparam int T_TAST = F_CLK / F_TAST;
   localparam int P_W    = T_BITS + 2*BITS;
   localparam int S_W    = T_BITS + 1;
   localparam logic [P_W-1:0]    T_TAST_P = P_W'(T_TAST);
   localparam logic [S_W-1:0]    T_TAST_S = S_W'(T_TAST);
   localparam logic [T_BITS-1:0] T_TAST_T = T_BITS'(T_TAST);

`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
   localparam int CNT_W = $clog2(T_BITS);
   typedef enum logic [1:0] {IDLE, MUL, SUM, DIV} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, SUM} state_t;
`endif

   // Zero-vector time split: T_0 gets the floor half, T_7 the remainder.
   function automatic logic [T_BITS-1:0] half_floor(input logic [S_W-1:0] t);
      return T_BITS'(t >> 1);
   endfunction

   function automatic logic [T_BITS-1:0] half_ceil(input logic [S_W-1:0] t);
      return T_BITS'(t - (t >> 1));
   endfunction

`ifndef AC_MOTOR_VECTOR_OVERMOD_EN
   function automatic logic [T_BITS-1:0] sat_tast(input logic [T_BITS-1:0] t);
      return (t > T_TAST_T) ? T_TAST_T : t;
   endfunction
`endif

   state_t            state_q, state_d;
   logic [BITS-1:0]   u_q, u_d, sp_q, sp_d, sn_q, sn_d;
   logic [P_W-1:0]    p1_q, p1_d, p2_q, p2_d;
   logic [T_BITS-1:0] t_0_q, t_0_d, t_1_q, t_1_d, t_2_q, t_2_d, t_7_q, t_7_d;
   logic              out_valid_q, out_valid_d, overmod_q, overmod_d;
   logic [T_BITS-1:0] t1, t2;
   logic [S_W-1:0]    s, t0;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
   logic [S_W-1:0]      rem_q, rem_d, div_q, div_d;
   logic [T_BITS-1:0]   dvd_q, dvd_d, quo_q, quo_d, q_new;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*T_BITS-1:0] n;
   logic [S_W:0]        trial;
   logic                ge;
`endif

   always_comb begin
      state_d     = state_q;
      u_d         = u_q;
      sp_d        = sp_q;
      sn_d        = sn_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      t_0_d       = t_0_q;
      t_1_d       = t_1_q;
      t_2_d       = t_2_q;
      t_7_d       = t_7_q;
      overmod_d   = overmod_q;
      out_valid_d = 1'b0;
      t1 = T_BITS'(p1_q >> (2*BITS));
      t2 = T_BITS'(p2_q >> (2*BITS));
      s  = {1'b0, t1} + {1'b0, t2};
      t0 = T_TAST_S - s;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
      rem_d = rem_q;
      div_d = div_q;
      dvd_d = dvd_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      // Dividend t1*T_TAST: upper half seeds the remainder (always < s), lower half is shifted in MSB first.
      n     = (2*T_BITS)'(t1) * (2*T_BITS)'(T_TAST);
      trial = {rem_q, dvd_q[T_BITS-1]};
      ge    = (trial >= {1'b0, div_q});
      q_new = (quo_q << 1) | T_BITS'(ge);
`endif
      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               u_d     = U_STR;
               sp_d    = SIN_POSITIVE;
               sn_d    = SIN_NEGATIVE;
               state_d = MUL;
            end
         end
         MUL: begin
            p1_d    = T_TAST_P * P_W'(u_q) * P_W'(sn_q);
            p2_d    = T_TAST_P * P_W'(u_q) * P_W'(sp_q);
            state_d = SUM;
         end
         SUM: begin
            if (s <= T_TAST_S) begin
               t_1_d       = t1;
               t_2_d       = t2;
               t_0_d       = half_floor(t0);
               t_7_d       = half_ceil(t0);
               overmod_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
               rem_d   = S_W'(n >> T_BITS);
               dvd_d   = T_BITS'(n);
               div_d   = s;
               quo_d   = '0;
               cnt_d   = '0;
               state_d = DIV;
`else
               t_1_d       = sat_tast(t1);
               t_2_d       = T_TAST_T - sat_tast(t1);
               t_0_d       = '0;
               t_7_d       = '0;
               overmod_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = IDLE;
`endif
            end
         end
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
         DIV: begin
            rem_d = S_W'(ge ? (trial - {1'b0, div_q}) : trial);
            dvd_d = dvd_q << 1;
            if (cnt_q == CNT_W'(T_BITS-1)) begin
               t_1_d       = q_new;
               t_2_d       = T_TAST_T - q_new;
               t_0_d       = '0;
               t_7_d       = '0;
               overmod_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               quo_d = q_new;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         u_q         <= '0;
         sp_q        <= '0;
         sn_q        <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         t_0_q       <= '0;
         t_1_q       <= '0;
         t_2_q       <= '0;
         t_7_q       <= '0;
         out_valid_q <= 1'b0;
         overmod_q   <= 1'b0;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
         rem_q       <= '0;
         div_q       <= '0;
         dvd_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         u_q         <= u_d;
         sp_q        <= sp_d;
         sn_q        <= sn_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         t_0_q       <= t_0_d;
         t_1_q       <= t_1_d;
         t_2_q       <= t_2_d;
         t_7_q       <= t_7_d;
         out_valid_q <= out_valid_d;
         overmod_q   <= overmod_d;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
         rem_q       <= rem_d;
         div_q       <= div_d;
         dvd_q       <= dvd_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign T_0       = t_0_q;
   assign T_1       = t_1_q;
   assign T_2       = t_2_q;
   assign T_7       = t_7_q;
   assign OUT_VALID = out_valid_q;
   assign OVERMOD   = overmod_q;

endmodule

// File: tb/tb_ac_motor_vector_dwell.sv
// Self-checking bench for ac_motor_vector_dwell; follows AC_MOTOR_VECTOR_OVERMOD_EN for the overmodulation expectations.
module tb_ac_motor_vector_dwell;
   localparam int BITS   = 12;
   localparam int T_BITS = 15;
   localparam int F_CLK  = 100000000;
   localparam int F_TAST = 10000;
   localparam int T_TAST = F_CLK / F_TAST;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
   localparam int OVM_LAT = 2 + T_BITS;
   localparam int N_SOAK  = 3000;
`else
   localparam int OVM_LAT = 2;
   localparam int N_SOAK  = 10000;
`endif

   logic              CLK;
   logic              RESET_N;
   logic              IN_VALID;
   logic              IN_READY;
   logic [BITS-1:0]   U_STR, SIN_POSITIVE, SIN_NEGATIVE;
   logic [T_BITS-1:0] T_0, T_1, T_2, T_7;
   logic              OUT_VALID, OVERMOD;

   int n_checks = 0;
   int n_fail   = 0;

   ac_motor_vector_dwell #(.BITS(BITS), .T_BITS(T_BITS), .F_CLK(F_CLK), .F_TAST(F_TAST)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .U_STR(U_STR), .SIN_POSITIVE(SIN_POSITIVE), .SIN_NEGATIVE(SIN_NEGATIVE),
      .T_0(T_0), .T_1(T_1), .T_2(T_2), .T_7(T_7),
      .OUT_VALID(OUT_VALID), .OVERMOD(OVERMOD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: dwell times straight from the arithmetic definition.
   function automatic void ref_dwell(input int u, input int sn, input int sp,
                                     output int e0, output int e1, output int e2, output int e7,
                                     output bit eovm, output int elat);
      longint scale, a1, a2, s, z;
      scale = longint'(1) << (2*BITS);
      a1 = (longint'(T_TAST) * u * sn) / scale;
      a2 = (longint'(T_TAST) * u * sp) / scale;
      s  = a1 + a2;
      if (s <= T_TAST) begin
         z    = T_TAST - s;
         e1   = int'(a1);
         e2   = int'(a2);
         e0   = int'(z / 2);
         e7   = int'(z - z / 2);
         eovm = 1'b0;
         elat = 2;
      end else begin
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
         e1 = int'((a1 * T_TAST) / s);
`else
         e1 = (a1 > T_TAST) ? T_TAST : int'(a1);
`endif
         e2   = T_TAST - e1;
         e0   = 0;
         e7   = 0;
         eovm = 1'b1;
         elat = OVM_LAT;
      end
   endfunction

   // Drives one sample and returns what the DUT produced; lat = edges after accept, -1 if none.
   task automatic run_txn(input int u, input int sn, input int sp, output int lat,
                          output int o0, output int o1, output int o2, output int o7, output bit ovm);
      lat = -1; o0 = -1; o1 = -1; o2 = -1; o7 = -1; ovm = 1'b0;
      @(negedge CLK);
      U_STR = BITS'(u); SIN_NEGATIVE = BITS'(sn); SIN_POSITIVE = BITS'(sp);
      IN_VALID = 1'b1;
      for (int w = 0; w < 50 && !IN_READY; w++) @(negedge CLK);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge CLK); #1;
         if (OUT_VALID) begin
            lat = e; o0 = int'(T_0); o1 = int'(T_1); o2 = int'(T_2); o7 = int'(T_7); ovm = OVERMOD;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; IN_VALID = 1'b0;
      U_STR = '0; SIN_POSITIVE = '0; SIN_NEGATIVE = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({T_0, T_1, T_2, T_7} !== '0) begin
         n_fail++; $display("FAIL reset_times got %0d/%0d/%0d/%0d want 0", T_0, T_1, T_2, T_7);
      end
      n_checks++;
      if (OUT_VALID !== 1'b0 || OVERMOD !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got valid=%0b ovm=%0b want 0/0", OUT_VALID, OVERMOD);
      end
      n_checks++;
      if (IN_READY !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %0b want 1", IN_READY);
      end
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic test_nominal();
      int lat, o0, o1, o2, o7; bit ovm;
      run_txn(4095, 2048, 0, lat, o0, o1, o2, o7, ovm);
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL nominal_latency got %0d want 2", lat); end
      n_checks++;
      if (o1 != 4998 || o2 != 0 || o0 != 2501 || o7 != 2501 || ovm !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_times got %0d/%0d/%0d/%0d ovm=%0b want 2501/4998/0/2501 ovm=0", o0, o1, o2, o7, ovm);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (OUT_VALID !== 1'b0 || T_1 !== 15'd4998) begin
         n_fail++; $display("FAIL nominal_hold got valid=%0b T_1=%0d want 0/4998", OUT_VALID, T_1);
      end
   endtask

   task automatic test_zero_index();
      int lat, o0, o1, o2, o7; bit ovm;
      for (int i = 0; i < 3; i++) begin
         run_txn(0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), lat, o0, o1, o2, o7, ovm);
         n_checks++;
         if (lat != 2 || o0 != 5000 || o1 != 0 || o2 != 0 || o7 != 5000 || ovm !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_index lat=%0d times %0d/%0d/%0d/%0d ovm=%0b want lat=2 5000/0/0/5000 ovm=0",
                     lat, o0, o1, o2, o7, ovm);
         end
      end
   endtask

   task automatic test_overmod();
      int lat, o0, o1, o2, o7; bit ovm;
      int w1, w2;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
      w1 = 5000; w2 = 5000;
`else
      w1 = 9995; w2 = 5;
`endif
      run_txn(4095, 4095, 4095, lat, o0, o1, o2, o7, ovm);
      n_checks++;
      if (lat != OVM_LAT) begin n_fail++; $display("FAIL overmod_latency got %0d want %0d", lat, OVM_LAT); end
      n_checks++;
      if (o1 != w1 || o2 != w2 || o0 != 0 || o7 != 0 || ovm !== 1'b1) begin
         n_fail++;
         $display("FAIL overmod_times got %0d/%0d/%0d/%0d ovm=%0b want 0/%0d/%0d/0 ovm=1", o0, o1, o2, o7, ovm, w1, w2);
      end
   endtask

   task automatic test_back_to_back();
      int su[5], sn[5], sp[5];
      int acc, pulses, last_pulse;
      int e0, e1, e2, e7, el; bit eo;
      bit take;
      for (int i = 0; i < 5; i++) begin
         su[i] = int'($urandom_range(0, 4095));
         sn[i] = int'($urandom_range(0, 2047));
         sp[i] = int'($urandom_range(0, 2047));
      end
      acc = 0; pulses = 0; last_pulse = -1;
      @(negedge CLK);
      U_STR = BITS'(su[0]); SIN_NEGATIVE = BITS'(sn[0]); SIN_POSITIVE = BITS'(sp[0]);
      IN_VALID = 1'b1;
      for (int cyc = 0; cyc < 40 && pulses < 5; cyc++) begin
         take = IN_VALID && IN_READY;
         @(posedge CLK); #1;
         if (take) begin
            acc++;
            if (acc < 5) begin
               U_STR = BITS'(su[acc]); SIN_NEGATIVE = BITS'(sn[acc]); SIN_POSITIVE = BITS'(sp[acc]);
            end else IN_VALID = 1'b0;
         end
         if (OUT_VALID) begin
            ref_dwell(su[pulses], sn[pulses], sp[pulses], e0, e1, e2, e7, eo, el);
            n_checks++;
            if (T_0 !== 15'(e0) || T_1 !== 15'(e1) || T_2 !== 15'(e2) || T_7 !== 15'(e7) || OVERMOD !== eo) begin
               n_fail++;
               $display("FAIL b2b_times[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        pulses, T_0, T_1, T_2, T_7, e0, e1, e2, e7);
            end
            if (last_pulse >= 0) begin
               n_checks++;
               if (cyc - last_pulse != 3) begin
                  n_fail++; $display("FAIL b2b_spacing got %0d want 3", cyc - last_pulse);
               end
            end
            last_pulse = cyc;
            pulses++;
         end else if (pulses > 0) begin
            ref_dwell(su[pulses-1], sn[pulses-1], sp[pulses-1], e0, e1, e2, e7, eo, el);
            n_checks++;
            if (T_1 !== 15'(e1) || T_0 !== 15'(e0)) begin
               n_fail++; $display("FAIL b2b_hold got T_1=%0d T_0=%0d want %0d/%0d", T_1, T_0, e1, e0);
            end
         end
         if (acc > 0 && pulses < 5) begin
            n_checks++;
            if (IN_READY !== OUT_VALID) begin
               n_fail++; $display("FAIL b2b_ready got ready=%0b want %0b", IN_READY, OUT_VALID);
            end
         end
      end
      n_checks++;
      if (pulses != 5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", pulses); end
      @(posedge CLK); #1;
      n_checks++;
      if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_tail got valid=%0b want 0", OUT_VALID); end
   endtask

   task automatic test_reset_mid();
      int lat, o0, o1, o2, o7; bit ovm;
      int e0, e1, e2, e7, el; bit eo;
      int pulses;
      int u, sn, sp;
      run_txn(4095, 2048, 0, lat, o0, o1, o2, o7, ovm);
      @(negedge CLK);
      U_STR = 12'd4095; SIN_NEGATIVE = 12'd4095; SIN_POSITIVE = 12'd4095;
      IN_VALID = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
`ifdef AC_MOTOR_VECTOR_OVERMOD_EN
      repeat (4) @(posedge CLK);
`else
      @(posedge CLK);
`endif
      #2 RESET_N = 1'b0;
      #1;
      n_checks++;
      if ({T_0, T_1, T_2, T_7} !== '0 || OUT_VALID !== 1'b0 || OVERMOD !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async got %0d/%0d/%0d/%0d v=%0b o=%0b want all 0", T_0, T_1, T_2, T_7, OUT_VALID, OVERMOD);
      end
      n_checks++;
      if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %0b want 1", IN_READY); end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      n_checks++;
      if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL midreset_release_ready got %0b want 1", IN_READY); end
      pulses = 0;
      repeat (25) begin
         @(posedge CLK); #1;
         if (OUT_VALID) pulses++;
      end
      n_checks++;
      if (pulses != 0 || {T_0, T_1, T_2, T_7} !== '0) begin
         n_fail++; $display("FAIL midreset_discard got pulses=%0d T_1=%0d want 0/0", pulses, T_1);
      end
      u = int'($urandom_range(0, 4095)); sn = int'($urandom_range(0, 4095)); sp = int'($urandom_range(0, 4095));
      ref_dwell(u, sn, sp, e0, e1, e2, e7, eo, el);
      run_txn(u, sn, sp, lat, o0, o1, o2, o7, ovm);
      n_checks++;
      if (lat != el || o0 != e0 || o1 != e1 || o2 != e2 || o7 != e7 || ovm !== eo) begin
         n_fail++;
         $display("FAIL midreset_recover lat=%0d %0d/%0d/%0d/%0d want lat=%0d %0d/%0d/%0d/%0d",
                  lat, o0, o1, o2, o7, el, e0, e1, e2, e7);
      end
   endtask

   task automatic test_random_soak();
      int lat, o0, o1, o2, o7; bit ovm;
      int e0, e1, e2, e7, el; bit eo;
      int u, sn, sp;
      for (int i = 0; i < N_SOAK; i++) begin
         u  = (i % 16 == 0) ? 4095 : int'($urandom_range(0, 4095));
         sn = int'($urandom_range(0, 4095));
         sp = (i % 16 == 1) ? 0 : int'($urandom_range(0, 4095));
         ref_dwell(u, sn, sp, e0, e1, e2, e7, eo, el);
         run_txn(u, sn, sp, lat, o0, o1, o2, o7, ovm);
         n_checks++;
         if (lat != el) begin
            n_fail++; $display("FAIL soak_latency[%0d] got %0d want %0d", i, lat, el);
         end
         n_checks++;
         if (o0 != e0 || o1 != e1 || o2 != e2 || o7 != e7 || ovm !== eo) begin
            n_fail++;
            $display("FAIL soak_times[%0d] u=%0d sn=%0d sp=%0d got %0d/%0d/%0d/%0d o=%0b want %0d/%0d/%0d/%0d o=%0b",
                     i, u, sn, sp, o0, o1, o2, o7, ovm, e0, e1, e2, e7, eo);
         end
         n_checks++;
         if (o0 + o1 + o2 + o7 != T_TAST || (o7 - o0) < 0 || (o7 - o0) > 1) begin
            n_fail++;
            $display("FAIL soak_invariant[%0d] got sum=%0d diff=%0d want %0d and 0..1", i, o0 + o1 + o2 + o7, o7 - o0, T_TAST);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero_index();
      test_overmod();
      test_back_to_back();
      test_reset_mid();
      test_random_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
